// File: rtl/fdtd_ez_sweep_ctrl_if.sv
// rtl/fdtd_ez_sweep_ctrl_if.sv - scheduler/field-RAM/calc bus of the Ez sweep sequencer
// perf_cycles exists only when FDTD_EZ_CTRL_PERF_EN is defined.
interface fdtd_ez_sweep_ctrl_if #(
    parameter int ADDR_WIDTH    = 10,
    parameter int N_SWEEP_WIDTH = 8
);
    logic                     start;
    logic                     abort;
    logic [ADDR_WIDTH:0]      cell_count;
    logic [N_SWEEP_WIDTH-1:0] n_sweeps;
    logic                     busy;
    logic                     done;
    logic                     sweep_done;
    logic                     fld_rd_en;
    logic [ADDR_WIDTH-1:0]    fld_rd_addr;
    logic                     calc_clken;
    logic                     ez_wr_en;
    logic [ADDR_WIDTH-1:0]    ez_wr_addr;
`ifdef FDTD_EZ_CTRL_PERF_EN
    logic [31:0]              perf_cycles;
`endif

    modport master (
`ifdef FDTD_EZ_CTRL_PERF_EN
        input  perf_cycles,
`endif
        output start, abort, cell_count, n_sweeps,
        input  busy, done, sweep_done, fld_rd_en, fld_rd_addr,
               calc_clken, ez_wr_en, ez_wr_addr
    );

    modport slave (
`ifdef FDTD_EZ_CTRL_PERF_EN
        output perf_cycles,
`endif
        input  start, abort, cell_count, n_sweeps,
        output busy, done, sweep_done, fld_rd_en, fld_rd_addr,
               calc_clken, ez_wr_en, ez_wr_addr
    );
endinterface

// File: rtl/fdtd_ez_sweep_ctrl.sv
// rtl/fdtd_ez_sweep_ctrl.sv - 1-D FDTD Ez sweep sequencer with delay-matched write-back
// Optional busy-cycle counter enabled by FDTD_EZ_CTRL_PERF_EN.
module fdtd_ez_sweep_ctrl #(
    parameter int ADDR_WIDTH    = 10,
    parameter int RD_LAT        = 1,
    parameter int CALC_LAT      = 4,
    parameter int N_SWEEP_WIDTH = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    fdtd_ez_sweep_ctrl_if.slave bus
);
    localparam int PIPE_LAT = RD_LAT + CALC_LAT;
    localparam int CNT_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_GAP,
        S_DONE
    } state_t;

    state_t                                 state;
    logic [ADDR_WIDTH-1:0]                  last_idx;
    logic [ADDR_WIDTH-1:0]                  rd_addr;
    logic [N_SWEEP_WIDTH-1:0]               sweeps_left;
    logic [CNT_W-1:0]                       drain_cnt;
    logic                                   rd_en;
    logic                                   clken;
    logic                                   done_q;
    logic                                   sweep_done_q;
    logic [PIPE_LAT-1:0]                    wr_vld;
    logic [PIPE_LAT-1:0][ADDR_WIDTH-1:0]    wr_idx;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= S_IDLE;
            last_idx     <= '0;
            rd_addr      <= '0;
            sweeps_left  <= '0;
            drain_cnt    <= '0;
            rd_en        <= 1'b0;
            clken        <= 1'b0;
            done_q       <= 1'b0;
            sweep_done_q <= 1'b0;
            wr_vld       <= '0;
            wr_idx       <= '0;
        end else begin
            done_q       <= 1'b0;
            sweep_done_q <= 1'b0;
            wr_vld[0]    <= rd_en;
            wr_idx[0]    <= rd_addr;
            for (int k = 1; k < PIPE_LAT; k++) begin
                wr_vld[k] <= wr_vld[k-1];
                wr_idx[k] <= wr_idx[k-1];
            end

            // Abort wins over everything and drops writes still in flight.
            if (bus.abort && state != S_IDLE) begin
                state   <= S_IDLE;
                rd_en   <= 1'b0;
                rd_addr <= '0;
                clken   <= 1'b0;
                wr_vld  <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            if (bus.cell_count >= (ADDR_WIDTH+1)'(2)) begin
                                last_idx    <= ADDR_WIDTH'(bus.cell_count - (ADDR_WIDTH+1)'(1));
                                sweeps_left <= (bus.n_sweeps == '0) ? N_SWEEP_WIDTH'(1) : bus.n_sweeps;
                                rd_addr     <= '0;
                                rd_en       <= 1'b1;
                                clken       <= 1'b1;
                                state       <= S_RUN;
                            end else begin
                                done_q <= 1'b1;
                                state  <= S_DONE;
                            end
                        end
                    end
                    S_RUN: begin
                        if (rd_addr == last_idx) begin
                            rd_en     <= 1'b0;
                            drain_cnt <= '0;
                            state     <= S_DRAIN;
                        end else begin
                            rd_addr <= rd_addr + ADDR_WIDTH'(1);
                        end
                    end
                    S_DRAIN: begin
                        if (drain_cnt == CNT_W'(PIPE_LAT - 1)) begin
                            sweep_done_q <= 1'b1;
                            if (sweeps_left != N_SWEEP_WIDTH'(1)) begin
                                sweeps_left <= sweeps_left - N_SWEEP_WIDTH'(1);
                                state       <= S_GAP;
                            end else begin
                                clken  <= 1'b0;
                                done_q <= 1'b1;
                                state  <= S_DONE;
                            end
                        end else begin
                            drain_cnt <= drain_cnt + CNT_W'(1);
                        end
                    end
                    S_GAP: begin
                        rd_addr <= '0;
                        rd_en   <= 1'b1;
                        state   <= S_RUN;
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Ez[0] is the PEC boundary and is never written.
    assign bus.ez_wr_en    = wr_vld[PIPE_LAT-1] && (wr_idx[PIPE_LAT-1] != '0);
    assign bus.ez_wr_addr  = wr_idx[PIPE_LAT-1];
    assign bus.fld_rd_en   = rd_en;
    assign bus.fld_rd_addr = rd_addr;
    assign bus.calc_clken  = clken;
    assign bus.done        = done_q;
    assign bus.sweep_done  = sweep_done_q;
    assign bus.busy        = (state != S_IDLE);

`ifdef FDTD_EZ_CTRL_PERF_EN
    logic [31:0] perf_cnt;

    // The DONE reporting cycle is left out so the count equals the active sweep cycles.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            perf_cnt <= '0;
        end else if (state == S_IDLE && bus.start) begin
            perf_cnt <= '0;
        end else if (state != S_IDLE && state != S_DONE && perf_cnt != 32'hFFFF_FFFF) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign bus.perf_cycles = perf_cnt;
`endif
endmodule
